// File: rtl/dds_voice_bank.sv
// ============================================================================
// Module      : dds_voice_bank
// Description : Time-multiplexed multi-voice DDS oscillator bank with a
//               summed output and valid/ready handshake with sticky overrun.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dds_voice_bank #(
    parameter int NV = 4,
    parameter int AW = 16,
    parameter int OW = 12,
    localparam int LW = $clog2(NV),
    localparam int MW = OW + LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wr_en,
    input  logic [LW-1:0] wr_voice,
    input  logic [1:0]    wr_sel,
    input  logic [AW-1:0] wr_data,
    output logic [MW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun
);

    localparam logic [LW-1:0] LAST_SLOT = LW'(NV - 1);
    localparam logic [OW-1:0] DUTY_RST  = {1'b1, {(OW-1){1'b0}}};

    logic [LW-1:0] r_slot;
    logic [MW-1:0] r_mix;

    logic [AW-1:0] w_acc  [NV];
    logic [1:0]    w_mode [NV];
    logic [OW-1:0] w_duty [NV];

    logic [OW-1:0] w_p;
    logic [OW-1:0] w_tri;
    logic [OW-1:0] w_wave;
    logic [MW-1:0] w_wave_ext;
    logic          w_load;

    // Per-voice state; a phase reset is written last so it overrides the accumulate
    for (genvar v = 0; v < NV; v++) begin : g_voice
        localparam logic [LW-1:0] VIDX = LW'(v);
        logic [AW-1:0] r_acc;
        logic [AW-1:0] r_tune;
        logic [1:0]    r_mode;
        logic [OW-1:0] r_duty;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc  <= '0;
                r_tune <= '0;
                r_mode <= 2'b00;
                r_duty <= DUTY_RST;
            end else begin
                if (en && (r_slot == VIDX))
                    r_acc <= r_acc + r_tune;
                if (wr_en && (wr_voice == VIDX)) begin
                    case (wr_sel)
                        2'b00:   r_tune <= wr_data;
                        2'b01:   r_mode <= wr_data[1:0];
                        2'b10:   r_duty <= wr_data[OW-1:0];
                        default: r_acc  <= '0;
                    endcase
                end
            end
        end

        assign w_acc[v]  = r_acc;
        assign w_mode[v] = r_mode;
        assign w_duty[v] = r_duty;
    end

    always_comb begin
        w_p    = w_acc[r_slot][AW-1 -: OW];
        w_tri  = {w_p[OW-2:0], 1'b0};
        w_wave = '0;
        case (w_mode[r_slot])
            2'b01:   w_wave = w_p;
            2'b10:   w_wave = (w_p < w_duty[r_slot]) ? {OW{1'b1}} : '0;
            2'b11:   w_wave = w_p[OW-1] ? ~w_tri : w_tri;
            default: w_wave = '0;
        endcase
    end

    assign w_wave_ext = {{LW{1'b0}}, w_wave};
    assign w_load     = en && (r_slot == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot    <= '0;
            r_mix     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (en) begin
                r_slot <= r_slot + 1'b1;
                if (r_slot == '0)
                    r_mix <= w_wave_ext;
                else if (r_slot != LAST_SLOT)
                    r_mix <= r_mix + w_wave_ext;
            end
            // A load during a handshake counts as accept-then-reload: valid stays set
            if (w_load) begin
                out_data  <= r_mix + w_wave_ext;
                out_valid <= 1'b1;
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
